dice_roll_scheduler: RTL and testbench
======================================

# dice_roll_scheduler

Shares one `dice_generator` between `N_PLAYERS` requesters for a turn-based dice game. Round-robin arbitration picks one request at a time. The block issues a single-cycle `roll` pulse and samples `dice_value` after a fixed settle delay, re-rolling out-of-range faces. It reports each result, accumulates per-player scores and declares a winner at a target score. It sits between the player-input logic and the `dice_generator` instance and is that instance's only driver of `roll`.

## Interface
- `N_PLAYERS`, 4: number of requesters, 2..8.
- `SETTLE`, 1: cycles between the `roll` pulse and the `dice_value` sample, 1..15.
- `TARGET`, 20: winning score threshold.
- `SCORE_W`, 8: width of each score.
- `MAX_RETRY`, 3: consecutive invalid faces allowed before an error result.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `new_game` in 1: synchronous clear, highest priority below `reset`.
- `req` in `N_PLAYERS`: level requests; each requester holds its line until it sees its own result.
- `roll` out 1: one-cycle pulse to `dice_generator`.
- `dice_value` in 3: face from `dice_generator`; only 1..6 are valid.
- `grant` out `N_PLAYERS`: one-hot, held from ROLL through RESULT.
- `busy` out 1: high whenever state is not IDLE.
- `result_valid` out 1: one-cycle pulse.
- `result_player` out `$clog2(N_PLAYERS)`: player id of the result.
- `result_value` out 3: face 1..6, or 0 on error.
- `result_err` out 1: set when retries are exhausted.
- `score` out `N_PLAYERS*SCORE_W`: packed; player i occupies bits `[i*SCORE_W +: SCORE_W]`.
- `winner_valid` out 1: held high while in GAMEOVER.
- `winner_id` out `$clog2(N_PLAYERS)`: id of the winning player.

## Operation
- States: IDLE, ROLL, WAIT, RESULT, GAMEOVER.
- **IDLE**: when any `req` is set, the round-robin arbiter picks the first requester after `last_grant`, wrapping. Register `grant`, `result_player` and `last_grant`. Go to ROLL.
- **ROLL**: `roll=1` for exactly one cycle. Load the settle counter with `SETTLE-1`. Go to WAIT.
- **WAIT**: decrement the counter. At the edge ending the cycle where the counter is 0, sample `dice_value`:
  - value 1..6: capture it and go to RESULT;
  - value 0 or 7: increment `retry`. If `retry < MAX_RETRY`, go to ROLL. Otherwise capture value 0, set the error flag and go to RESULT.
- **RESULT**: `result_valid=1`.
  - If there is no error, the granted player's score adds the face, saturating at 2^SCORE_W−1. The updated score is visible on the next cycle.
  - Clear `retry`.
  - If the new score is ≥ `TARGET`, go to GAMEOVER and load `winner_id`. Otherwise go to IDLE.
- **GAMEOVER**: `winner_valid=1`. Requests are ignored and `grant=0`.
- `new_game`, in any state: clear scores, `retry`, `winner_valid`, `grant` and `last_grant`, then go to IDLE. If `roll` would have been high that cycle, it is suppressed.
- A `req` dropped mid-turn does not abort the turn; the result is still produced for the granted player.
- Only one roll is in flight at a time, so tied winners are impossible.

## Timing
- Reset values:
  - all outputs 0; all scores 0;
  - `last_grant = N_PLAYERS-1`, so player 0 wins the first arbitration;
  - state IDLE.
- With `req` seen in IDLE at cycle t:
  - `grant` and `busy` rise at t+1, `roll` is high at t+1;
  - WAIT occupies t+2..t+1+SETTLE;
  - `result_valid` is high at t+2+SETTLE;
  - IDLE resumes at t+3+SETTLE.
- Each invalid face adds 1+SETTLE cycles.
- Back-to-back throughput: one turn per 3+SETTLE cycles.
- All outputs are registered or decoded from the state register, with no combinational path from `req` or `dice_value` to any output.

## Structure
- Package `dice_pkg` holds:
  - the state enum;
  - `DIE_MIN=1`, `DIE_MAX=6`;
  - a function `face_ok(logic [2:0])`.
- Sub-module `rr_arbiter`, parameterised by `N`, takes inputs `req` and `last_grant` and returns a one-hot `gnt` plus its index. It is purely combinational and selected in IDLE.

## Test plan
- **Reset, then one roll.** Assert `reset` mid-WAIT. `roll` drops immediately, all outputs go to 0 and no result appears. After release, `req=4'b0001` with a stub returning 3 gives `roll` at t+1, `result_valid` at t+3 with player 0 and value 3, and `score[0]=3`.
- **Round-robin rotation.** With `req=4'b1111` held, the grant order is 0,1,2,3,0. Turns are spaced 4 cycles apart at `SETTLE=1`.
- **Invalid faces.** The stub returns 7, then 0, then 5. This produces three `roll` pulses and a single result with value 5 and `result_err=0`. Returning 7 four times produces a result with value 0, `result_err=1`, and no change to the score.
- **Win detection.** Preload player 2 to 18 via rolls, then roll a 4. The score becomes 22, `winner_valid=1` and `winner_id=2`. Further `req` produce no `roll`.
- **`new_game` during ROLL.** `roll` is suppressed, scores are cleared and the state returns to IDLE. The next grant goes to player 0.
- **`SETTLE=4` build.** The result arrives at t+6. The stub value changes while WAIT is in progress, and only the value present at the final WAIT edge is captured.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice roll scheduler.
// Holds the FSM state encoding and the legal-face check used when sampling the generator.
package dice_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROLL,
    ST_WAIT,
    ST_RESULT,
    ST_GAMEOVER
  } state_t;

  localparam logic [2:0] DIE_MIN = 3'd1;
  localparam logic [2:0] DIE_MAX = 3'd6;

  // The generator can emit 0 or 7; only 1..6 count as a real face.
  function automatic logic face_ok(input logic [2:0] face);
    return (face >= DIE_MIN) && (face <= DIE_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts just after last_grant and wraps, so the previous winner has the lowest priority.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  localparam int IDX_W = $clog2(N);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= N; off++) begin
      cand     = (int'(last_grant) + off) % N;
      cand_idx = IDX_W'(cand);
      if (!gnt_valid && req[cand_idx]) begin
        gnt_valid     = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dice_roll_scheduler.sv
// Shares one dice generator between several players: arbitrates requests, rolls and re-rolls,
// reports each face, keeps per-player scores and stops the game once someone reaches TARGET.
module dice_roll_scheduler
  import dice_pkg::*;
#(
  parameter int N_PLAYERS = 4,
  parameter int SETTLE    = 1,
  parameter int TARGET    = 20,
  parameter int SCORE_W   = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           new_game,
  input  logic [N_PLAYERS-1:0]           req,
  output logic                           roll,
  input  logic [2:0]                     dice_value,
  output logic [N_PLAYERS-1:0]           grant,
  output logic                           busy,
  output logic                           result_valid,
  output logic [$clog2(N_PLAYERS)-1:0]   result_player,
  output logic [2:0]                     result_value,
  output logic                           result_err,
  output logic [N_PLAYERS*SCORE_W-1:0]   score,
  output logic                           winner_valid,
  output logic [$clog2(N_PLAYERS)-1:0]   winner_id
);

  localparam int PID_W   = $clog2(N_PLAYERS);
  localparam int CNT_W   = 4;
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam int SUM_W   = SCORE_W + 1;

  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [SUM_W-1:0]   TARGET_EXT  = SUM_W'(TARGET);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [PID_W-1:0]   LAST_INIT   = PID_W'(N_PLAYERS - 1);

  state_t               state;
  state_t               state_d;
  logic [N_PLAYERS-1:0] grant_q;
  logic [PID_W-1:0]     last_grant;
  logic [CNT_W-1:0]     settle_cnt;
  logic [RETRY_W-1:0]   retry;
  logic [SCORE_W-1:0]   score_q [N_PLAYERS];

  logic [N_PLAYERS-1:0] arb_gnt;
  logic [PID_W-1:0]     arb_idx;
  logic                 arb_valid;

  logic                 settle_done;
  logic                 face_good;
  logic                 retry_left;
  logic [SUM_W-1:0]     sum;
  logic [SCORE_W-1:0]   new_score;
  logic                 wins;

  rr_arbiter #(
    .N (N_PLAYERS)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx),
    .gnt_valid  (arb_valid)
  );

  // Score the player would hold after the current result; error results leave it untouched.
  always_comb begin
    settle_done = (settle_cnt == '0);
    face_good   = face_ok(dice_value);
    retry_left  = (retry < RETRY_LIMIT);
    sum         = SUM_W'(score_q[result_player]) + SUM_W'(result_value);
    if (result_err) begin
      new_score = score_q[result_player];
    end else if (sum[SCORE_W]) begin
      new_score = SCORE_MAX;
    end else begin
      new_score = sum[SCORE_W-1:0];
    end
    wins = ({1'b0, new_score} >= TARGET_EXT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    if (new_game) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:     if (arb_valid) state_d = ST_ROLL;
        ST_ROLL:     state_d = ST_WAIT;
        ST_WAIT: begin
          if (settle_done) begin
            if (face_good)       state_d = ST_RESULT;
            else if (retry_left) state_d = ST_ROLL;
            else                 state_d = ST_RESULT;
          end
        end
        ST_RESULT:   state_d = wins ? ST_GAMEOVER : ST_IDLE;
        ST_GAMEOVER: state_d = ST_GAMEOVER;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // A new_game arriving in ROLL must keep the generator from seeing a pulse.
  always_comb begin
    roll         = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    winner_valid = 1'b0;
    grant        = '0;
    unique case (state)
      ST_IDLE:     busy = 1'b0;
      ST_ROLL: begin
        roll  = !new_game;
        grant = grant_q;
      end
      ST_WAIT:     grant = grant_q;
      ST_RESULT: begin
        grant        = grant_q;
        result_valid = 1'b1;
      end
      ST_GAMEOVER: winner_valid = 1'b1;
      default:     busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q       <= '0;
      last_grant    <= LAST_INIT;
      settle_cnt    <= '0;
      retry         <= '0;
      result_player <= '0;
      result_value  <= '0;
      result_err    <= 1'b0;
      winner_id     <= '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        score_q[i] <= '0;
      end
    end else if (new_game) begin
      grant_q    <= '0;
      last_grant <= LAST_INIT;
      retry      <= '0;
      winner_id  <= '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        score_q[i] <= '0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q       <= arb_gnt;
            result_player <= arb_idx;
            last_grant    <= arb_idx;
          end
        end
        ST_ROLL: settle_cnt <= SETTLE_LOAD;
        ST_WAIT: begin
          if (!settle_done) begin
            settle_cnt <= settle_cnt - 1'b1;
          end else if (face_good) begin
            result_value <= dice_value;
            result_err   <= 1'b0;
          end else begin
            retry <= retry + 1'b1;
            if (!retry_left) begin
              result_value <= '0;
              result_err   <= 1'b1;
            end
          end
        end
        ST_RESULT: begin
          retry                  <= '0;
          score_q[result_player] <= new_score;
          if (wins) begin
            winner_id <= result_player;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_score
    assign score[i*SCORE_W +: SCORE_W] = score_q[i];
  end

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Directed bench for dice_roll_scheduler: a queue-driven generator stub feeds the SETTLE=1 instance,
// and a second SETTLE=4 instance checks that only the face present at the last WAIT edge is taken.
module tb_dice_roll_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game;
  logic [3:0]  req;
  logic        roll;
  logic [2:0]  dice_value = 3'd0;
  logic [3:0]  grant;
  logic        busy;
  logic        result_valid;
  logic [1:0]  result_player;
  logic [2:0]  result_value;
  logic        result_err;
  logic [31:0] score;
  logic        winner_valid;
  logic [1:0]  winner_id;

  logic        new_game_s4;
  logic [3:0]  req_s4;
  logic        roll_s4;
  logic [2:0]  dv_s4;
  logic [3:0]  grant_s4;
  logic        busy_s4;
  logic        rv_s4;
  logic [1:0]  rp_s4;
  logic [2:0]  rval_s4;
  logic        rerr_s4;
  logic [31:0] score_s4;
  logic        wv_s4;
  logic [1:0]  wid_s4;

  logic [2:0]  stub_q [$];
  int          roll_count = 0;
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  dice_roll_scheduler #(
    .N_PLAYERS (4), .SETTLE (1), .TARGET (20), .SCORE_W (8), .MAX_RETRY (3)
  ) dut (
    .clk (clk), .reset (reset), .new_game (new_game), .req (req), .roll (roll),
    .dice_value (dice_value), .grant (grant), .busy (busy), .result_valid (result_valid),
    .result_player (result_player), .result_value (result_value), .result_err (result_err),
    .score (score), .winner_valid (winner_valid), .winner_id (winner_id)
  );

  dice_roll_scheduler #(
    .N_PLAYERS (4), .SETTLE (4), .TARGET (20), .SCORE_W (8), .MAX_RETRY (3)
  ) dut_s4 (
    .clk (clk), .reset (reset), .new_game (new_game_s4), .req (req_s4), .roll (roll_s4),
    .dice_value (dv_s4), .grant (grant_s4), .busy (busy_s4), .result_valid (rv_s4),
    .result_player (rp_s4), .result_value (rval_s4), .result_err (rerr_s4),
    .score (score_s4), .winner_valid (wv_s4), .winner_id (wid_s4)
  );

  // Generator stub: each roll pulse presents the next queued face for the following cycles.
  always @(posedge clk) begin
    if (roll) begin
      roll_count <= roll_count + 1;
      if (stub_q.size() > 0) dice_value <= stub_q.pop_front();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!result_valid && cyc < 60);
    check_output("result_timeout", 32'(result_valid), 1);
  endtask

  initial begin
    int cyc;
    int rc;
    int exp_g;
    int faces [3] = '{6, 6, 4};

    reset = 1'b1; new_game = 1'b0; req = '0;
    new_game_s4 = 1'b0; req_s4 = '0; dv_s4 = '0;
    tick(); tick();
    check_output("rst_roll", 32'(roll), 0);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_grant", 32'(grant), 0);
    check_output("rst_rv", 32'(result_valid), 0);
    check_output("rst_score", score, 0);
    check_output("rst_winner", 32'(winner_valid), 0);

    // Start a turn, then hit reset in the middle of WAIT.
    reset = 1'b0;
    stub_q.push_back(3'd3);
    req = 4'b0001;
    tick();
    check_output("pre_roll", 32'(roll), 1);
    tick();
    check_output("pre_wait_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check_output("midrst_roll", 32'(roll), 0);
    check_output("midrst_busy", 32'(busy), 0);
    check_output("midrst_grant", 32'(grant), 0);
    req = '0;
    tick();
    reset = 1'b0;
    tick(); tick();
    check_output("midrst_no_result", 32'(result_valid), 0);
    check_output("midrst_score", score, 0);

    // One clean roll of 3 for player 0.
    stub_q.push_back(3'd3);
    req = 4'b0001;
    tick();
    check_output("t1_roll", 32'(roll), 1);
    check_output("t1_grant", 32'(grant), 32'h1);
    tick();
    check_output("t2_roll_low", 32'(roll), 0);
    tick();
    check_output("t3_rv", 32'(result_valid), 1);
    check_output("t3_player", 32'(result_player), 0);
    check_output("t3_value", 32'(result_value), 3);
    check_output("t3_err", 32'(result_err), 0);
    req = '0;
    tick();
    check_output("t4_idle", 32'(busy), 0);
    check_output("t4_score0", 32'(score[7:0]), 3);

    // Round robin from a fresh game with every line held.
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check_output("ng_score", score, 0);
    repeat (5) stub_q.push_back(3'd2);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_g = 1 << (k % 4);
      check_output($sformatf("rr_grant%0d", k), 32'(grant), 32'(exp_g));
      check_output($sformatf("rr_roll%0d", k), 32'(roll), 1);
      if (k == 4) req = '0;
      tick(); tick(); tick();
    end
    check_output("rr_scores", score, 32'h02020204);

    // Faces 7 and 0 are re-rolled before a good 5.
    stub_q.push_back(3'd7); stub_q.push_back(3'd0); stub_q.push_back(3'd5);
    rc = roll_count;
    req = 4'b0010;
    wait_result(cyc);
    check_output("inv_cycles", 32'(cyc), 7);
    check_output("inv_rolls", 32'(roll_count - rc), 3);
    check_output("inv_value", 32'(result_value), 5);
    check_output("inv_err", 32'(result_err), 0);
    check_output("inv_player", 32'(result_player), 1);
    req = '0;
    tick();
    check_output("inv_score1", 32'(score[15:8]), 7);

    // Four bad faces in a row exhaust the retries.
    repeat (4) stub_q.push_back(3'd7);
    rc = roll_count;
    req = 4'b0100;
    wait_result(cyc);
    check_output("err_cycles", 32'(cyc), 9);
    check_output("err_rolls", 32'(roll_count - rc), 4);
    check_output("err_value", 32'(result_value), 0);
    check_output("err_flag", 32'(result_err), 1);
    check_output("err_player", 32'(result_player), 2);
    req = '0;
    tick();
    check_output("err_score2", 32'(score[23:16]), 2);

    // Player 2 climbs 2 -> 18, then a 4 takes it over the target.
    stub_q.push_back(3'd6); stub_q.push_back(3'd6);
    stub_q.push_back(3'd4); stub_q.push_back(3'd4);
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      wait_result(cyc);
      check_output($sformatf("win_face%0d", k), 32'(result_value), 32'(faces[k]));
    end
    tick();
    check_output("win_pre18", 32'(score[23:16]), 18);
    wait_result(cyc);
    check_output("win_face_last", 32'(result_value), 4);
    tick();
    check_output("win_valid", 32'(winner_valid), 1);
    check_output("win_id", 32'(winner_id), 2);
    check_output("win_score", 32'(score[23:16]), 22);
    check_output("win_grant", 32'(grant), 0);
    rc = roll_count;
    repeat (6) tick();
    check_output("win_no_roll", 32'(roll_count - rc), 0);
    check_output("win_held", 32'(winner_valid), 1);

    // Leave GAMEOVER and give player 1 a turn so last_grant is non-default.
    req = '0;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check_output("go_clear_winner", 32'(winner_valid), 0);
    check_output("go_clear_busy", 32'(busy), 0);
    check_output("go_clear_score", score, 0);
    stub_q.push_back(3'd2);
    req = 4'b0010;
    wait_result(cyc);
    check_output("go_player1", 32'(result_player), 1);
    req = '0;
    tick();

    // new_game lands on a ROLL cycle.
    stub_q.push_back(3'd1);
    req = 4'b1111;
    tick();
    check_output("ngr_roll_before", 32'(roll), 1);
    new_game = 1'b1;
    #1;
    check_output("ngr_roll_supp", 32'(roll), 0);
    rc = roll_count;
    tick();
    new_game = 1'b0;
    check_output("ngr_idle", 32'(busy), 0);
    check_output("ngr_score", score, 0);
    tick();
    check_output("ngr_grant0", 32'(grant), 32'h1);
    check_output("ngr_roll", 32'(roll), 1);
    check_output("ngr_no_pulse", 32'(roll_count - rc), 0);
    req = '0;
    wait_result(cyc);
    check_output("ngr_player", 32'(result_player), 0);
    check_output("ngr_value", 32'(result_value), 1);

    // SETTLE=4 instance: the face keeps changing during WAIT; only the last one counts.
    req_s4 = 4'b0001;
    tick();
    check_output("s4_roll", 32'(roll_s4), 1);
    dv_s4 = 3'd1;
    tick(); dv_s4 = 3'd2;
    tick(); dv_s4 = 3'd3;
    tick(); dv_s4 = 3'd4;
    tick(); dv_s4 = 3'd6;
    check_output("s4_not_yet", 32'(rv_s4), 0);
    tick();
    check_output("s4_rv", 32'(rv_s4), 1);
    check_output("s4_value", 32'(rval_s4), 6);
    check_output("s4_player", 32'(rp_s4), 0);
    req_s4 = '0;
    tick();
    check_output("s4_score", 32'(score_s4[7:0]), 6);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
